// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
//
// Hazard/stall controller for the 5-stage pipeline.
//
// A D-stage instruction stalls when one of its source registers is produced by
// an instruction in E or M that will not have the value ready by the cycle it
// is needed. This is the Tnew > Tuse check. An instruction that touches the
// mult/div unit also stalls while that unit is busy, or while a mult/div is
// starting in E this cycle.
//
// A stall freezes PC and IF/ID, and clears ID/EX, so one bubble enters E.
// All stall outputs are purely combinational from the current-cycle inputs.
//
// Parameters
//   MULT_CYC    busy cycles after mult/multu leaves E
//   DIV_CYC     busy cycles after div/divu leaves E
//
// Ports
//   clk         pipeline clock
//   reset       synchronous, active-high
//   d_rs/d_rt   D-stage source register indices
//   d_tuse_*    D-stage Tuse per source (3 = source not read)
//   d_is_md     D-stage instruction uses the mult/div unit or HI/LO
//   e_wa/e_tnew E-stage destination (0 = none) and Tnew
//   m_wa/m_tnew M-stage destination (0 = none) and Tnew
//   e_md_start  E-stage instruction is mult/multu/div/divu
//   e_md_div    with e_md_start: 1 = div/divu, 0 = mult/multu
//   pc_en       PC write enable
//   fd_en       IF/ID register enable
//   de_clr      ID/EX synchronous clear (bubble insert)
//   stall       stall in this cycle
//   md_busy     mult/div busy counter is nonzero
//   stall_cnt   stall cycles since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_clr,
  output logic        stall,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  // The busy counter must hold the longer of the two latencies. It is never
  // narrower than 4 bits.
  localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // ---------------------------------------------------------------------------
  // Register hazard for one source operand.
  // The producer in E or M matches the source register, and its result
  // arrives later than the consumer needs it.
  // ---------------------------------------------------------------------------
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] ewa,
    input logic [1:0] etnew,
    input logic [4:0] mwa,
    input logic [1:0] mtnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (src == ewa) && (etnew > tuse);
    m_hit = (src == mwa) && (mtnew > tuse);
    // $zero is hard-wired, so a write to it can never be a real dependency.
    return (tuse != TUSE_NONE) && (src != 5'd0) && (e_hit || m_hit);
  endfunction

  logic             hz_rs;
  logic             hz_rt;
  logic             hz_md;
  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;
  logic [31:0]      stall_cnt_q;
  logic [31:0]      stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Hazard detection and pipeline control (combinational, no added latency)
  // ---------------------------------------------------------------------------
  always_comb begin
    hz_rs = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
    hz_rt = src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
    // A start in E counts as busy already. The counter only loads at the
    // end of this cycle, so the start cycle itself must also stall.
    hz_md = d_is_md && ((md_cnt_q != '0) || e_md_start);
  end

  assign stall   = hz_rs | hz_rt | hz_md;
  assign pc_en   = ~stall;
  assign fd_en   = ~stall;
  assign de_clr  = stall;
  assign md_busy = (md_cnt_q != '0);

  // ---------------------------------------------------------------------------
  // Mult/div busy counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    md_cnt_d = md_cnt_q;
    if (e_md_start) begin
      // A new start always reloads, even over a busy count.
      md_cnt_d = e_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values, whatever the order of statements.
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl
//
// Directed testbench for stall_ctrl, with hand-computed expectations.
// Inputs change 1 ns after each rising edge. Outputs are sampled 1 ns later,
// well away from the next edge.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_is_md;
  logic [4:0]  e_wa;
  logic [1:0]  e_tnew;
  logic [4:0]  m_wa;
  logic [1:0]  m_tnew;
  logic        e_md_start;
  logic        e_md_div;
  logic        pc_en;
  logic        fd_en;
  logic        de_clr;
  logic        stall;
  logic        md_busy;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int n_stall;

  stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_is_md    (d_is_md),
    .e_wa       (e_wa),
    .e_tnew     (e_tnew),
    .m_wa       (m_wa),
    .m_tnew     (m_tnew),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .de_clr     (de_clr),
    .stall      (stall),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, then land 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_is_md = 1'b0; e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_div = 1'b0;
  endtask

  // Hold an md instruction in D. A mult/div start is pulsed in cycle 0 with
  // kind first_div. An optional div restart is pulsed in cycle restart_at.
  // The task returns the number of cycles in which stall was seen.
  task automatic md_run(input logic first_div, input int restart_at, output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      d_is_md    = 1'b1;
      e_md_start = (c == 0) || (c == restart_at);
      e_md_div   = (c == 0) ? first_div : 1'b1;
      #1;
      if (stall) n++;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;

    // 1. Reset for two cycles, then idle inputs.
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_pc_en",  {31'd0, pc_en},   32'd1);
    check("rst_fd_en",  {31'd0, fd_en},   32'd1);
    check("rst_de_clr", {31'd0, de_clr},  32'd0);
    check("rst_stall",  {31'd0, stall},   32'd0);
    check("rst_busy",   {31'd0, md_busy}, 32'd0);
    check("rst_cnt",    stall_cnt,        32'd0);

    // 2. E-stage rs hazard, then Tnew drops. All within one cycle.
    tick();
    d_rs = 5'd8; d_tuse_rs = 2'd0; e_wa = 5'd8; e_tnew = 2'd2; #1;
    check("e_rs_stall",  {31'd0, stall},  32'd1);
    check("e_rs_declr",  {31'd0, de_clr}, 32'd1);
    check("e_rs_pc_en",  {31'd0, pc_en},  32'd0);
    check("e_rs_fd_en",  {31'd0, fd_en},  32'd0);
    e_tnew = 2'd0; #1;
    check("e_rs_tnew0",  {31'd0, stall},  32'd0);
    // The rs index is not read: no stall.
    e_tnew = 2'd2; d_tuse_rs = 2'd3; #1;
    check("e_rs_noread", {31'd0, stall},  32'd0);
    // M-stage producer: Tnew 1 > Tuse 0 stalls, Tnew 1 == Tuse 1 does not.
    idle(); d_rs = 5'd8; d_tuse_rs = 2'd0; m_wa = 5'd8; m_tnew = 2'd1; #1;
    check("m_rs_stall",  {31'd0, stall},  32'd1);
    d_tuse_rs = 2'd1; #1;
    check("m_rs_equal",  {31'd0, stall},  32'd0);

    // 3. Register 0 is exempt. A nonzero rt still stalls.
    idle(); d_rt = 5'd0; d_tuse_rt = 2'd0; e_wa = 5'd0; e_tnew = 2'd2; #1;
    check("rt_zero",     {31'd0, stall},  32'd0);
    d_rt = 5'd5; e_wa = 5'd5; #1;
    check("rt_hazard",   {31'd0, stall},  32'd1);
    d_rt = 5'd5; e_wa = 5'd6; #1;
    check("rt_other_wa", {31'd0, stall},  32'd0);
    idle();

    // 4. md busy windows: mult gives 1 + 5 stall cycles, div gives 1 + 10.
    tick();
    md_run(1'b0, -1, n_stall);
    check("md_mult_len", n_stall, 32'd6);
    check("md_mult_idle", {31'd0, md_busy}, 32'd0);
    md_run(1'b1, -1, n_stall);
    check("md_div_len",  n_stall, 32'd11);
    // A div restart in cycle 2 of a mult: 2 cycles, then 1 start, then 10 busy.
    md_run(1'b0, 2, n_stall);
    check("md_reload",   n_stall, 32'd13);
    // A start without an md instruction in D: busy, but no stall.
    e_md_start = 1'b1; e_md_div = 1'b0; #1;
    check("md_nod_stall", {31'd0, stall}, 32'd0);
    tick(); idle(); #1;
    check("md_nod_busy", {31'd0, md_busy}, 32'd1);
    check("md_nod_stall2", {31'd0, stall}, 32'd0);

    // 5. Reset during a div busy window.
    tick();
    e_md_start = 1'b1; e_md_div = 1'b1;
    tick(); idle();
    tick(); tick(); #1;
    check("mid_busy",    {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("mid_rst_busy", {31'd0, md_busy}, 32'd0);
    check("mid_rst_cnt", stall_cnt, 32'd0);

    // 6. Seven stall cycles. The first cycle carries a register hazard and an
    //    md hazard together, so it must count once.
    for (int c = 0; c < 7; c++) begin
      idle();
      d_rs = 5'd3; d_tuse_rs = 2'd0; e_wa = 5'd3; e_tnew = 2'd1;
      if (c == 0) begin
        d_is_md = 1'b1; e_md_start = 1'b1;
      end
      tick();
    end
    idle(); #1;
    check("cnt_seven",   stall_cnt, 32'd7);
    tick(); #1;
    check("cnt_hold",    stall_cnt, 32'd7);

    // Saturation: preload the counter near all-ones.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #2;
    release dut.stall_cnt_q;
    #1;
    check("sat_preload", stall_cnt, 32'hFFFF_FFFE);
    d_rs = 5'd3; d_tuse_rs = 2'd0; e_wa = 5'd3; e_tnew = 2'd1;
    tick();
    check("sat_reach",   stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat_hold1",   stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat_hold2",   stall_cnt, 32'hFFFF_FFFF);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
